// File: rtl/tanh_pwl_pipe.sv
// Three-stage, multi-lane fixed-point tanh unit with valid/ready flow control.
// Uses an 8-segment piecewise-linear fit over |x| < 4, saturates beyond that, and has a per-beat bypass.
module tanh_pwl_pipe #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic                    i_in_mode,
    input  logic [LANES*DATA_W-1:0] i_in_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [LANES*DATA_W-1:0] o_out_data,
    output logic [LANES-1:0]        o_out_sat
);

    localparam int FRAC_W = DATA_W - 4;
    localparam int TW     = FRAC_W - 1;
    localparam int RSH    = 16 - FRAC_W;

    localparam logic [DATA_W:0]   ONE_A   = (DATA_W+1)'(1);
    localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(1);
    localparam logic [DATA_W-1:0] UNITY_Q = DATA_W'(1) << FRAC_W;

    // Knots are tanh(k/2) in unsigned Q0.16; index 8 closes the last segment.
    function automatic logic [15:0] knot(input logic [3:0] idx);
        case (idx)
            4'd0:    knot = 16'd0;
            4'd1:    knot = 16'd30285;
            4'd2:    knot = 16'd49912;
            4'd3:    knot = 16'd59320;
            4'd4:    knot = 16'd63179;
            4'd5:    knot = 16'd64659;
            4'd6:    knot = 16'd65212;
            4'd7:    knot = 16'd65417;
            default: knot = 16'd65492;
        endcase
    endfunction

    logic w_adv;
    logic r_s1_valid, r_s2_valid, r_out_valid;
    logic r_s1_mode, r_s2_mode;

    assign w_adv       = !r_out_valid || i_out_ready;
    assign o_in_ready  = w_adv;
    assign o_out_valid = r_out_valid;

    // NOTE: <= in every clocked block so all stages sample the pre-edge values of the stage before.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= i_in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
        end
    end

    // NOTE: payload registers carry no reset; the reset-controlled valid bits decide what is presented.
    always_ff @(posedge i_clk) begin
        if (w_adv) begin
            r_s1_mode <= i_in_mode;
            r_s2_mode <= r_s1_mode;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_W-1:0] w_x;
        logic [DATA_W:0]   w_ext, w_abs;

        // One extra bit so the most negative input still has a representable magnitude.
        assign w_x   = i_in_data[g*DATA_W +: DATA_W];
        assign w_ext = {w_x[DATA_W-1], w_x};
        assign w_abs = w_x[DATA_W-1] ? (~w_ext + ONE_A) : w_ext;

        logic [DATA_W-1:0] r_s1_x;
        logic              r_s1_sat;
        logic [2:0]        r_s1_k;
        logic [TW-1:0]     r_s1_t;

        always_ff @(posedge i_clk) begin
            if (w_adv) begin
                r_s1_x   <= w_x;
                r_s1_sat <= |w_abs[DATA_W:FRAC_W+2];
                r_s1_k   <= w_abs[FRAC_W+1:FRAC_W-1];
                r_s1_t   <= w_abs[FRAC_W-2:0];
            end
        end

        logic [15:0]    w_base, w_next, w_diff, w_p;
        logic [15+TW:0] w_prod;

        assign w_base = knot({1'b0, r_s1_k});
        assign w_next = knot({1'b0, r_s1_k} + 4'd1);
        assign w_diff = w_next - w_base;
        assign w_prod = (16+TW)'(w_diff) * (16+TW)'(r_s1_t);
        assign w_p    = 16'(w_prod >> TW);

        logic [DATA_W-1:0] r_s2_x;
        logic              r_s2_sat;
        logic [15:0]       r_s2_base, r_s2_p;

        always_ff @(posedge i_clk) begin
            if (w_adv) begin
                r_s2_x    <= r_s1_x;
                r_s2_sat  <= r_s1_sat;
                r_s2_base <= w_base;
                r_s2_p    <= w_p;
            end
        end

        logic [16:0]       w_y;
        logic [FRAC_W:0]   w_m;
        logic [DATA_W-1:0] w_mag, w_res;

        assign w_y = {1'b0, r_s2_base} + {1'b0, r_s2_p};

        if (RSH > 0) begin : g_round
            logic [16:0] w_rnd;
            assign w_rnd = w_y + (17'(1) << (RSH - 1));
            assign w_m   = (FRAC_W+1)'(w_rnd >> RSH);
        end else begin : g_exact
            assign w_m = (FRAC_W+1)'(w_y);
        end

        assign w_mag = r_s2_sat ? UNITY_Q : DATA_W'(w_m);
        assign w_res = r_s2_x[DATA_W-1] ? (~w_mag + ONE_D) : w_mag;

        logic [DATA_W-1:0] r_y;
        logic              r_sat;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_y   <= '0;
                r_sat <= 1'b0;
            end else if (w_adv) begin
                r_y   <= r_s2_mode ? r_s2_x : w_res;
                r_sat <= !r_s2_mode && r_s2_sat;
            end
        end

        assign o_out_data[g*DATA_W +: DATA_W] = r_y;
        assign o_out_sat[g]                   = r_sat;
    end

endmodule

// File: doc/tanh_pwl_pipe.md
# tanh_pwl_pipe

Pipelined, multi-lane fixed-point tanh activation unit with valid/ready flow control. It replaces the pass-through Tanh operator stub in the activation path. It uses an 8-segment piecewise-linear approximation over |x| < 4, saturates beyond that range, and has a per-beat bypass (identity) mode. Fixed latency is 3 cycles, and the whole pipeline stalls under downstream back-pressure.

## Interface
- DATA_W, 16: lane width. Signed format Q3.FRAC_W with FRAC_W = DATA_W-4. Legal range is 8..20.
- LANES, 4: number of lanes processed in parallel per beat.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- in_mode  input  1  0 = tanh, 1 = bypass. Sampled with the beat and carried through the pipe.
- in_data  input  LANES*DATA_W  packed signed lanes; lane i is bits [i*DATA_W +: DATA_W].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  LANES*DATA_W  packed results, same lane order as in_data.
- out_sat  output  LANES  per-lane flag: the lane took the saturation path.

## Operation
- Knot table K[0..8] is unsigned Q0.16, with K[k] = round(tanh(k/2)·65536): 0, 30285, 49912, 59320, 63179, 64659, 65212, 65417, 65492.
- Stage 1, per lane:
  - s = sign bit.
  - a = |x|, computed in DATA_W+1 bits so that the most-negative input is handled.
  - sat = (a >= 4.0, i.e. a >= 2^(FRAC_W+2)).
  - k = a[FRAC_W+1 : FRAC_W-1], giving 3 bits.
  - t = a[FRAC_W-2 : 0], giving FRAC_W-1 bits.
- Stage 2, per lane: p = ((K[k+1]-K[k]) · t) >> (FRAC_W-1), truncating.
- Stage 3, per lane:
  - y16 = K[k] + p.
  - m = (y16 + 2^(15-FRAC_W)) >> (16-FRAC_W), i.e. round half up on magnitude. When FRAC_W = 16 there is no rounding and m = y16.
  - If sat, then m = 2^FRAC_W (exactly 1.0).
  - The result is s ? -m : m.
- Bypass beats: out_data = in_data, out_sat = 0, same 3-cycle latency.
- All lanes share a single valid, mode and stall. There is no per-lane handshake.
- The output magnitude never exceeds 1.0, so there is no overflow.

## Timing
- The pipeline is three register stages, S1→S2→S3. The S3 registers drive the outputs.
- Advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from the out_valid register and out_ready.
  - On adv, every stage captures the stage before it. S1 captures in_valid & in_ready.
  - When adv = 0, all stages hold.
- Handshake and latency:
  - A beat is accepted on a cycle where in_valid && in_ready.
  - Its result is on out_valid/out_data 3 cycles after acceptance, if there is no stall.
  - Each stall cycle adds one cycle.
- Output hold: while out_valid && !out_ready, out_data, out_sat and out_valid stay stable.
- Bubbles occupy stages but are never presented; out_valid is 0 for them.
- Full throughput: one beat per cycle while out_ready = 1.
- The valid bits of S1 to S3 are reset-controlled.
- Data registers are enable-gated. out_data and out_sat also reset to 0.
- Reset:
  - Values: out_valid = 0, out_data = 0, out_sat = 0, all stage valids = 0.
  - in_ready = 1 in the first cycle after reset, because out_valid = 0.
  - Reset mid-stream discards all in-flight beats. No beat accepted before reset produces output.
- Simultaneous events:
  - out_ready and in_valid in the same cycle: the output beat retires and a new beat enters S1 on that edge.
  - rst has priority over every other event.

## Test plan
- Reset and basic tanh, DATA_W=16, lane0:
  - in_data lane0 = 0x0800 (0.5) and lane1 = 0x0000, mode 0, out_ready=1.
  - Required 3 cycles after acceptance: lane0 = 0x0765 (1893), lane1 = 0x0000, out_sat = 0.
  - All outputs are 0 and out_valid=0 before the beat arrives.
- Negative and interpolation, lane0 and lane1:
  - lane0 = 0xF000 (-1.0) and lane1 = 0x0C00 (0.75).
  - Required: lane0 = 0xF3D0 (-3120) and lane1 = 0x09CA (2506).
- Saturation, lane0 to lane2:
  - lane0 = 0x4000 (4.0), lane1 = 0x8000 (-8.0), lane2 = 0x3FFF.
  - Required: lane0 = 0x1000 and lane1 = 0xF000, with out_sat = 0b0011. lane2 is not saturated.
- Back-pressure:
  - Stream 6 beats with in_valid=1 while out_ready=0.
  - Required: exactly 3 beats accepted, and in_ready=0 from the cycle out_valid rises.
  - Raising out_ready drains all 6 beats in order with no loss or duplication, one per cycle.
- Bypass and mixed mode: alternate mode 0 and mode 1 beats each cycle with x=0x0800.
  - Bypass beats output 0x0800 with out_sat=0.
  - Tanh beats output 0x0765.
- Reset mid-operation:
  - Assert rst for 1 cycle with 2 beats in flight.
  - Required: out_valid stays 0 until a new beat is accepted, and neither discarded beat ever appears.
